stepdown_corestate_seq: RTL

Sequencer for the stepdown core power stage. It owns start-up, soft-start ramp, PWM generation with dead time, overcurrent hiccup and power-good for the high-side/low-side gate-drive cells. It sits in the STEPDOWN CORESTATE hierarchy, upstream of the generated gate logic bricks (nand2/inv drivers), which it enables through `hs_en`/`ls_en`.

---
 rtl/stepdown_pkg.sv | 24 ++
 rtl/stepdown_deadtime.sv | 54 +++++
 rtl/stepdown_corestate_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/stepdown_pkg.sv
// Shared types and default constants for the stepdown core sequencer.
package stepdown_pkg;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_SOFTSTART = 2'd1,
        ST_RUN       = 2'd2,
        ST_HICCUP    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SIDE_NONE = 2'd0,
        SIDE_HS   = 2'd1,
        SIDE_LS   = 2'd2
    } side_e;

    localparam int DEF_SS_W      = 6;
    localparam int DEF_SS_DIV    = 16;
    localparam int DEF_PER_W     = 8;
    localparam int DEF_DT_CYC    = 2;
    localparam int DEF_OCP_MAX   = 4;
    localparam int DEF_RETRY_CYC = 1024;

endpackage

// File: rtl/stepdown_deadtime.sv
// Break-before-make gate enables: both sides off for DT_CYC clocks on
// every side change, and whenever gating is withheld.
module stepdown_deadtime
    import stepdown_pkg::*;
#(
    parameter int DT_CYC = DEF_DT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic hs_req,
    input  logic gate_allow,
    output logic hs_en,
    output logic ls_en
);
    localparam int TW = $clog2(DT_CYC + 1);

    side_e         side_q;
    side_e         tgt;
    logic [TW-1:0] dt_q;
    logic          hs_q;
    logic          ls_q;

    assign tgt   = hs_req ? SIDE_HS : SIDE_LS;
    assign hs_en = hs_q;
    assign ls_en = ls_q;

    // NONE after a withheld cycle forces a fresh dead window on re-entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            side_q <= SIDE_NONE;
            dt_q   <= '0;
            hs_q   <= 1'b0;
            ls_q   <= 1'b0;
        end else if (!gate_allow) begin
            side_q <= SIDE_NONE;
            dt_q   <= '0;
            hs_q   <= 1'b0;
            ls_q   <= 1'b0;
        end else if (tgt != side_q) begin
            side_q <= tgt;
            dt_q   <= TW'(DT_CYC - 1);
            hs_q   <= 1'b0;
            ls_q   <= 1'b0;
        end else if (dt_q != '0) begin
            dt_q   <= dt_q - TW'(1);
            hs_q   <= 1'b0;
            ls_q   <= 1'b0;
        end else begin
            hs_q   <= (side_q == SIDE_HS);
            ls_q   <= (side_q == SIDE_LS);
        end
    end

endmodule

// File: rtl/stepdown_corestate_seq.sv
// Stepdown core power-stage sequencer: start-up FSM, soft-start ramp,
// PWM period counter, cycle-by-cycle OCP with hiccup, and power-good.
module stepdown_corestate_seq
    import stepdown_pkg::*;
#(
    parameter int SS_W      = DEF_SS_W,
    parameter int SS_DIV    = DEF_SS_DIV,
    parameter int PER_W     = DEF_PER_W,
    parameter int DT_CYC    = DEF_DT_CYC,
    parameter int OCP_MAX   = DEF_OCP_MAX,
    parameter int RETRY_CYC = DEF_RETRY_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CELV,
    input  logic             CELG,
    input  logic             SUB,
    input  logic             en,
    input  logic             uvlo_ok,
    input  logic [PER_W-1:0] duty,
    input  logic             ocp,
    output logic             hs_en,
    output logic             ls_en,
    output logic [SS_W-1:0]  ss_code,
    output logic             pgood,
    output logic             fault,
    output logic [1:0]       state
);
    localparam int DW = $clog2(SS_DIV + 1);
    localparam int OW = $clog2(OCP_MAX + 1);
    localparam int RW = $clog2(RETRY_CYC + 1);

    state_e           state_q, state_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [SS_W-1:0]  ss_q, ss_d, ss_inc;
    logic [DW-1:0]    div_q, div_d;
    logic [OW-1:0]    ocp_cnt_q, ocp_cnt_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             lim_q, lim_d;
    logic             pgood_q, fault_q;

    logic             go, run_q, run_d, enter_ss;
    logic             wrap, lim, trip;
    logic             ss_step, ss_done, retry_done;
    logic [PER_W-1:0] ss_lvl, eff;
    logic             hs_req;
    logic             unused_pins;

    assign unused_pins = CELV ^ CELG ^ SUB;

    assign go       = en & uvlo_ok;
    assign run_q    = (state_q == ST_SOFTSTART) || (state_q == ST_RUN);
    assign run_d    = (state_d == ST_SOFTSTART) || (state_d == ST_RUN);
    assign enter_ss = (state_d == ST_SOFTSTART) && (state_q != ST_SOFTSTART);

    // an ocp seen in the wrap cycle still belongs to the period ending
    assign wrap    = run_q && (cnt_q == '1);
    assign lim     = lim_q | ocp;
    assign trip    = wrap && lim && (ocp_cnt_q >= OW'(OCP_MAX - 1));
    assign ss_inc  = ss_q + SS_W'(1);
    assign ss_step = (state_q == ST_SOFTSTART) && (div_q == DW'(SS_DIV - 1));
    assign ss_done = ss_step && (&ss_inc);
    assign retry_done = (retry_q == RW'(RETRY_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            ss_q      <= '0;
            div_q     <= '0;
            ocp_cnt_q <= '0;
            retry_q   <= '0;
            lim_q     <= 1'b0;
            pgood_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ss_q      <= ss_d;
            div_q     <= div_d;
            ocp_cnt_q <= ocp_cnt_d;
            retry_q   <= retry_d;
            lim_q     <= lim_d;
            pgood_q   <= (state_d == ST_RUN);
            if (state_d == ST_HICCUP && state_q != ST_HICCUP)
                fault_q <= 1'b1;
            else if (!en && state_q != ST_OFF)
                fault_q <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!go) begin
            state_d = ST_OFF;
        end else begin
            unique case (state_q)
                ST_OFF:       state_d = ST_SOFTSTART;
                ST_SOFTSTART: begin
                    if (trip)         state_d = ST_HICCUP;
                    else if (ss_done) state_d = ST_RUN;
                end
                ST_RUN:       if (trip) state_d = ST_HICCUP;
                ST_HICCUP:    if (retry_done) state_d = ST_SOFTSTART;
                default:      state_d = ST_OFF;
            endcase
        end
    end

    always_comb begin
        cnt_d     = cnt_q + PER_W'(1);
        ss_d      = ss_q;
        div_d     = div_q;
        ocp_cnt_d = ocp_cnt_q;
        lim_d     = wrap ? 1'b0 : lim;
        retry_d   = '0;
        if (state_q == ST_HICCUP)
            retry_d = retry_q + RW'(1);
        if (ss_step) begin
            ss_d  = ss_inc;
            div_d = '0;
        end else if (state_q == ST_SOFTSTART) begin
            div_d = div_q + DW'(1);
        end
        if (wrap) begin
            if (!lim)
                ocp_cnt_d = '0;
            else if (ocp_cnt_q != OW'(OCP_MAX))
                ocp_cnt_d = ocp_cnt_q + OW'(1);
        end
        if (!run_d || enter_ss) begin
            cnt_d     = '0;
            ss_d      = '0;
            div_d     = '0;
            ocp_cnt_d = '0;
            lim_d     = 1'b0;
        end
    end

    assign ss_lvl = PER_W'(ss_q) << (PER_W - SS_W);

    always_comb begin
        eff = '0;
        unique case (state_q)
            ST_SOFTSTART: eff = (duty < ss_lvl) ? duty : ss_lvl;
            ST_RUN:       eff = duty;
            default:      eff = '0;
        endcase
    end

    assign hs_req = (cnt_q < eff) && !lim;

    stepdown_deadtime #(
        .DT_CYC(DT_CYC)
    ) u_deadtime (
        .clk       (clk),
        .rst       (rst),
        .hs_req    (hs_req),
        .gate_allow(run_d),
        .hs_en     (hs_en),
        .ls_en     (ls_en)
    );

    assign ss_code = ss_q;
    assign pgood   = pgood_q;
    assign fault   = fault_q;
    assign state   = state_q;

endmodule
